multdiv_ctrl: RTL and testbench

MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

---
 rtl/multdiv_ctrl.sv | 130 +++++++++++++
 tb/tb_multdiv_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multdiv_ctrl.sv
// Multi-cycle multiply/divide sequencer owning the architectural HI/LO registers.
// Define MULTDIV_CANCEL_EN to add the exception-flush input 'cancel'.
module multdiv_ctrl #(
  parameter int MULT_CYC = 5,
  parameter int DIV_CYC  = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [1:0]  MULTDIVop,
  input  logic        MULTDIVwe,
  input  logic        HiLo,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        md_use_D,
`ifdef MULTDIV_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] MULT_LD = 5'(MULT_CYC - 1);
  localparam logic [4:0] DIV_LD  = 5'(DIV_CYC - 1);

  state_t      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        kill;

`ifdef MULTDIV_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  // Multiply: one 64x64 truncated product of sign- or zero-extended operands.
  logic [63:0] ext_a, ext_b, product;
  assign ext_a   = {{32{op_q[0] & a_q[31]}}, a_q};
  assign ext_b   = {{32{op_q[0] & b_q[31]}}, b_q};
  assign product = ext_a * ext_b;

  // Divide on magnitudes so INT_MIN / -1 wraps to INT_MIN instead of overflowing.
  logic        neg_a, neg_b;
  logic [31:0] mag_a, mag_b, q_mag, r_mag, quot, rem;
  assign neg_a = op_q[0] & a_q[31];
  assign neg_b = op_q[0] & b_q[31];
  assign mag_a = neg_a ? (~a_q + 32'd1) : a_q;
  assign mag_b = neg_b ? (~b_q + 32'd1) : b_q;
  assign q_mag = mag_a / mag_b;
  assign r_mag = mag_a % mag_b;
  assign quot  = (neg_a ^ neg_b) ? (~q_mag + 32'd1) : q_mag;
  assign rem   = neg_a ? (~r_mag + 32'd1) : r_mag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 5'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      op_q    <= 2'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      IDLE: begin
        if (start && !kill) begin
          a_d     = A;
          b_d     = B;
          op_d    = MULTDIVop;
          cnt_d   = MULTDIVop[1] ? DIV_LD : MULT_LD;
          state_d = RUN;
        end else if (MULTDIVwe && !kill) begin
          if (HiLo) hi_d = A;
          else      lo_d = A;
        end
      end
      RUN: begin
        if (kill) begin
          cnt_d   = 5'd0;
          state_d = IDLE;
        end else if (cnt_q == 5'd0) begin
          // Commit as RUN ends so the result is visible the cycle busy drops.
          state_d = DONE;
          if (!op_q[1]) begin
            hi_d = product[63:32];
            lo_d = product[31:0];
          end else if (b_q != 32'd0) begin
            hi_d = rem;
            lo_d = quot;
          end
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy  = (state_q == RUN);
  assign stall = md_use_D & (start | busy);
  assign HI    = hi_q;
  assign LO    = lo_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Directed bench for multdiv_ctrl: arithmetic reference model checked every cycle,
// plus literal expectations for the documented example transactions.
module tb_multdiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  MULTDIVop = 2'b00;
  logic        MULTDIVwe = 1'b0;
  logic        HiLo = 1'b0;
  logic [31:0] A = 32'd0;
  logic [31:0] B = 32'd0;
  logic        md_use_D = 1'b0;
  logic        cancel = 1'b0;
  logic        busy, stall;
  logic [31:0] HI, LO;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  multdiv_ctrl #(.MULT_CYC(5), .DIV_CYC(10)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .MULTDIVop(MULTDIVop),
    .MULTDIVwe(MULTDIVwe), .HiLo(HiLo), .A(A), .B(B), .md_use_D(md_use_D),
`ifdef MULTDIV_CANCEL_EN
    .cancel(cancel),
`endif
    .busy(busy), .stall(stall), .HI(HI), .LO(LO)
  );

  logic kill;
`ifdef MULTDIV_CANCEL_EN
  assign kill = cancel;
`else
  assign kill = 1'b0;
`endif

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  // Reference arithmetic in 64-bit integers.
  function automatic void calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                               output logic [31:0] h, output logic [31:0] l, output bit skip);
    longint sa, sb, p, q, r;
    sa = op[0] ? longint'($signed(a)) : longint'({32'd0, a});
    sb = op[0] ? longint'($signed(b)) : longint'({32'd0, b});
    skip = 1'b0;
    h = 32'd0;
    l = 32'd0;
    if (!op[1]) begin
      p = sa * sb;
      h = p[63:32];
      l = p[31:0];
    end else if (b == 32'd0) begin
      skip = 1'b1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      l = q[31:0];
      h = r[31:0];
    end
  endfunction

  logic [31:0] c_h, c_l;
  bit          c_s;
  always_comb calc(MULTDIVop, A, B, c_h, c_l, c_s);

  // Model: busy cycles remaining, one recovery cycle after completion, pending result.
  int          m_left;
  bit          m_cool;
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  bit          p_skip;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_left <= 0;
      m_cool <= 1'b0;
      m_hi   <= 32'd0;
      m_lo   <= 32'd0;
      p_hi   <= 32'd0;
      p_lo   <= 32'd0;
      p_skip <= 1'b0;
    end else if (kill) begin
      m_left <= 0;
      m_cool <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_cool <= 1'b1;
        if (!p_skip) begin
          m_hi <= p_hi;
          m_lo <= p_lo;
        end
      end
    end else if (m_cool) begin
      m_cool <= 1'b0;
    end else if (start) begin
      m_left <= MULTDIVop[1] ? 10 : 5;
      p_hi   <= c_h;
      p_lo   <= c_l;
      p_skip <= c_s;
    end else if (MULTDIVwe) begin
      if (HiLo) m_hi <= A;
      else      m_lo <= A;
    end
  end

  always @(negedge clk) begin
    chk("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
    chk("stall", {31'd0, stall}, {31'd0, md_use_D & (start | (m_left > 0))});
    chk("HI", HI, m_hi);
    chk("LO", LO, m_lo);
  end

  task automatic run_op(input string nm, input logic [1:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_cyc, input logic [31:0] eh,
                        input logic [31:0] el, input bit inject, input bit we_too);
    int  n;
    bit  done;
    @(posedge clk); #2;
    start = 1'b1; MULTDIVop = op; A = a; B = b;
    if (we_too) begin
      MULTDIVwe = 1'b1; HiLo = 1'b1;
    end
    n = 0;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      @(posedge clk); #2;
      start = 1'b0; MULTDIVwe = 1'b0;
      A = $urandom; B = $urandom;
      if (busy) begin
        n++;
        if (md_use_D) chk({nm, "_stall_busy"}, {31'd0, stall}, 32'd1);
        if (inject && n == 3) begin
          start = 1'b1; MULTDIVop = 2'b10; A = 32'd99; B = 32'd3;
        end
      end else begin
        done = 1'b1;
      end
    end
    if (!done) begin
      failures++;
      $display("FAIL %s_timeout busy never fell", nm);
    end
    chk({nm, "_cycles"}, n, exp_cyc);
    chk({nm, "_HI"}, HI, eh);
    chk({nm, "_LO"}, LO, el);
    if (md_use_D) chk({nm, "_stall_fall"}, {31'd0, stall}, 32'd0);
    $display("txn %s op=%b A=%h B=%h busy_cycles=%0d HI=%h LO=%h", nm, op, a, b, n, HI, LO);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_HI", HI, 32'd0);
    chk("reset_LO", LO, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;

    run_op("mult",  2'b01, 32'hFFFFFFFE, 32'd3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA, 1'b0, 1'b0);
    run_op("multu", 2'b00, 32'hFFFFFFFE, 32'd3, 5, 32'h00000002, 32'hFFFFFFFA, 1'b0, 1'b0);
    run_op("div",   2'b11, 32'hFFFFFFF9, 32'd2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu0", 2'b10, 32'd7, 32'd0, 10, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divovf", 2'b11, 32'h80000000, 32'hFFFFFFFF, 10, 32'h00000000, 32'h80000000, 1'b0, 1'b0);
    run_op("divneg", 2'b11, 32'd7, 32'hFFFFFFFE, 10, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0);
    run_op("divu",  2'b10, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0, 1'b0);

    md_use_D = 1'b1;
    run_op("mult_inj", 2'b01, 32'd6, 32'hFFFFFFF9, 5, 32'hFFFFFFFF, 32'hFFFFFFD6, 1'b1, 1'b0);
    md_use_D = 1'b0;

    // mthi / mtlo
    @(posedge clk); #2;
    MULTDIVwe = 1'b1; HiLo = 1'b1; A = 32'h12345678;
    @(posedge clk); #2;
    MULTDIVwe = 1'b0;
    chk("mthi_HI", HI, 32'h12345678);
    chk("mthi_LO", LO, 32'hFFFFFFD6);
    chk("mthi_busy", {31'd0, busy}, 32'd0);
    $display("txn mthi A=12345678 HI=%h LO=%h", HI, LO);
    MULTDIVwe = 1'b1; HiLo = 1'b0; A = 32'hABCD0123;
    @(posedge clk); #2;
    MULTDIVwe = 1'b0;
    chk("mtlo_LO", LO, 32'hABCD0123);
    chk("mtlo_HI", HI, 32'h12345678);
    $display("txn mtlo A=abcd0123 HI=%h LO=%h", HI, LO);

    run_op("start_we", 2'b00, 32'd2, 32'd3, 5, 32'd0, 32'd6, 1'b0, 1'b1);

    // Reset in the fourth busy cycle of a divide.
    @(posedge clk); #2;
    start = 1'b1; MULTDIVop = 2'b11; A = 32'd100; B = 32'd7;
    @(posedge clk); #2;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_HI", HI, 32'd0);
    chk("rst_LO", LO, 32'd0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    #2;
    chk("post_rst_HI", HI, 32'd0);
    chk("post_rst_LO", LO, 32'd0);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    $display("txn reset_during_div HI=%h LO=%h busy=%b", HI, LO, busy);

`ifdef MULTDIV_CANCEL_EN
    run_op("pre_cancel", 2'b00, 32'd5, 32'd9, 5, 32'd0, 32'd45, 1'b0, 1'b0);
    @(posedge clk); #2;
    start = 1'b1; MULTDIVop = 2'b01; A = 32'd1000; B = 32'd1000;
    @(posedge clk); #2;
    start = 1'b0;
    @(posedge clk); #2;
    cancel = 1'b1;
    @(posedge clk); #2;
    cancel = 1'b0;
    chk("cancel_busy", {31'd0, busy}, 32'd0);
    repeat (8) @(posedge clk);
    #2;
    chk("cancel_HI", HI, 32'd0);
    chk("cancel_LO", LO, 32'd45);
    $display("txn cancel_mult HI=%h LO=%h busy=%b", HI, LO, busy);
`endif

    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
